// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and mux-select encodings for the multicycle controller
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef struct packed {
    logic r;
    logic i_alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } inst_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational RV32I opcode classifier (one-hot class plus illegal)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int SUPPORT_UPPER_JUMP = 1
) (
  input  logic [31:0] inst,
  output inst_class_t cls,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign unused_bits = ^{inst[31:15], inst[11:7]};

  // An illegal instruction leaves every class bit clear so the one-hot stays clean.
  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls.r     = 1'b1;
      OP_IMM:    cls.i_alu = 1'b1;
      OP_LOAD:   cls.load  = 1'b1;
      OP_STORE:  cls.store = 1'b1;
      OP_BRANCH: begin
        if (funct3[2:1] == 2'b00) cls.branch = 1'b1;
        else                      illegal    = 1'b1;
      end
      OP_JAL:   begin
        if (SUPPORT_UPPER_JUMP != 0) cls.jal = 1'b1;
        else                         illegal = 1'b1;
      end
      OP_JALR:  begin
        if (SUPPORT_UPPER_JUMP != 0) cls.jalr = 1'b1;
        else                         illegal  = 1'b1;
      end
      OP_LUI:   begin
        if (SUPPORT_UPPER_JUMP != 0) cls.lui = 1'b1;
        else                         illegal = 1'b1;
      end
      OP_AUIPC: begin
        if (SUPPORT_UPPER_JUMP != 0) cls.auipc = 1'b1;
        else                         illegal   = 1'b1;
      end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I main control FSM with memory wait and timeout trap
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES     = 15,
  parameter int SUPPORT_UPPER_JUMP = 1,
  parameter int ALUOP_W            = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        inst,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               reg_write,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               trap,
  output logic [2:0]         state_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);

  state_t            state, next_state;
  logic [CNT_W-1:0]  wait_cnt;
  inst_class_t       cls;
  logic              illegal;
  logic              timeout;
  logic [1:0]        alu_op_c;

  ctrl_decode #(
    .SUPPORT_UPPER_JUMP(SUPPORT_UPPER_JUMP)
  ) u_decode (
    .inst   (inst),
    .cls    (cls),
    .illegal(illegal)
  );

  assign timeout = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_VAL) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if ((next_state == FETCH || next_state == MEM) && next_state != state)
        wait_cnt <= '0;
      else if ((state == FETCH || state == MEM) && !mem_ready && wait_cnt != CNT_MAX)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = WB_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op_c   = ALU_ADD;
    pc_src     = PC_SRC_ALU;
    trap       = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end else if (timeout) begin
          next_state = TRAP;
        end
      end
      DECODE: begin
        // Branch/jal target is precomputed here and held in ALUOut for EXEC.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_IMM;
        next_state = illegal ? TRAP : EXEC;
      end
      EXEC: begin
        next_state = WB;
        if (cls.r) begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op_c  = ALU_FUNCT;
        end else if (cls.i_alu) begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op_c  = ALU_FUNCT;
        end else if (cls.load || cls.store) begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          next_state = MEM;
        end else if (cls.branch) begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_op_c   = ALU_SUB;
          pc_src     = PC_SRC_ALUOUT;
          pc_write   = zero ^ inst[12];
          next_state = FETCH;
        end else if (cls.jal) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_ALUOUT;
        end else if (cls.jalr) begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          pc_write  = 1'b1;
        end else if (cls.lui) begin
          alu_src_a = SRC_A_ZERO;
          alu_src_b = SRC_B_IMM;
        end else if (cls.auipc) begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
        end else begin
          next_state = FETCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = cls.store;
        if (mem_ready)    next_state = cls.load ? WB : FETCH;
        else if (timeout) next_state = TRAP;
      end
      WB: begin
        reg_write = 1'b1;
        if (cls.load)                mem_to_reg = WB_MDR;
        else if (cls.jal || cls.jalr) mem_to_reg = WB_PC;
        next_state = FETCH;
      end
      TRAP:    trap = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  assign alu_op  = ALUOP_W'(alu_op_c);
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic clk;
  int   checks;
  int   errors;

  logic        rst_a, ready_a, zero_a;
  logic [31:0] inst_a;
  logic        pcw_a, irw_a, req_a, we_a, iord_a, rw_a, trap_a;
  logic [1:0]  m2r_a, sa_a, sb_a, op_a, pcs_a;
  logic [2:0]  st_a;

  logic        rst_b, ready_b, zero_b;
  logic [31:0] inst_b;
  logic        pcw_b, irw_b, req_b, we_b, iord_b, rw_b, trap_b;
  logic [1:0]  m2r_b, sa_b, sb_b, op_b, pcs_b;
  logic [2:0]  st_b;

  logic [19:0] obs_a, obs_b;

  multicycle_controller u_dut_a (
    .clk(clk), .rst_n(rst_a), .inst(inst_a), .mem_ready(ready_a), .zero(zero_a),
    .pc_write(pcw_a), .ir_write(irw_a), .mem_req(req_a), .mem_we(we_a), .i_or_d(iord_a),
    .reg_write(rw_a), .mem_to_reg(m2r_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
    .alu_op(op_a), .pc_src(pcs_a), .trap(trap_a), .state_o(st_a)
  );

  multicycle_controller #(
    .TIMEOUT_CYCLES(4), .SUPPORT_UPPER_JUMP(0), .ALUOP_W(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b), .inst(inst_b), .mem_ready(ready_b), .zero(zero_b),
    .pc_write(pcw_b), .ir_write(irw_b), .mem_req(req_b), .mem_we(we_b), .i_or_d(iord_b),
    .reg_write(rw_b), .mem_to_reg(m2r_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
    .alu_op(op_b), .pc_src(pcs_b), .trap(trap_b), .state_o(st_b)
  );

  assign obs_a = {pcw_a, irw_a, req_a, we_a, iord_a, rw_a, m2r_a, sa_a, sb_a, op_a, pcs_a, trap_a, st_a};
  assign obs_b = {pcw_b, irw_b, req_b, we_b, iord_b, rw_b, m2r_b, sa_b, sb_b, op_b, pcs_b, trap_b, st_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobes = {pc_write, ir_write, mem_req, mem_we, i_or_d, reg_write}
  function automatic logic [19:0] ev(input logic [2:0] st, input logic [5:0] strobes,
                                     input logic [1:0] m2r, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] pcs, input logic tr);
    return {strobes, m2r, a, b, op, pcs, tr, st};
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] e_idle, e_fetch_rdy, e_fetch_wait, e_decode, e_exec_r, e_wb_alu;
  logic [19:0] e_exec_mem, e_mem_ld, e_mem_st, e_wb_ld, e_exec_bt, e_exec_bn;
  logic [19:0] e_exec_jal, e_wb_pc, e_trap;

  initial begin
    checks = 0;
    errors = 0;
    e_idle       = ev(3'd0, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    e_fetch_rdy  = ev(3'd1, 6'b111000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
    e_fetch_wait = ev(3'd1, 6'b001000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
    e_decode     = ev(3'd2, 6'b000000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
    e_exec_r     = ev(3'd3, 6'b000000, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0);
    e_wb_alu     = ev(3'd5, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    e_exec_mem   = ev(3'd3, 6'b000000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
    e_mem_ld     = ev(3'd4, 6'b001010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    e_mem_st     = ev(3'd4, 6'b001110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    e_wb_ld      = ev(3'd5, 6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    e_exec_bt    = ev(3'd3, 6'b100000, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0);
    e_exec_bn    = ev(3'd3, 6'b000000, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0);
    e_exec_jal   = ev(3'd3, 6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    e_wb_pc      = ev(3'd5, 6'b000001, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    e_trap       = ev(3'd6, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

    rst_a = 1'b0; ready_a = 1'b1; zero_a = 1'b0; inst_a = 32'h002081B3;
    rst_b = 1'b0; ready_b = 1'b1; zero_b = 1'b0; inst_b = 32'h0000006F;
    #1;
    chk("reset_a", obs_a, e_idle);
    chk("reset_b", obs_b, e_idle);

    // add x3,x1,x2 with zero-wait memory
    @(negedge clk); rst_a = 1'b1; #1;
    chk("add_idle", obs_a, e_idle);
    tick(); chk("add_fetch", obs_a, e_fetch_rdy);
    tick(); chk("add_decode", obs_a, e_decode);
    tick(); chk("add_exec", obs_a, e_exec_r);
    tick(); chk("add_wb", obs_a, e_wb_alu);
    tick(); chk("add_refetch", obs_a, e_fetch_rdy);

    // lw x3,0(x1) with three wait cycles in MEM
    inst_a = 32'h0000A183;
    tick(); chk("lw_decode", obs_a, e_decode);
    tick(); chk("lw_exec", obs_a, e_exec_mem);
    ready_a = 1'b0;
    tick(); chk("lw_mem0", obs_a, e_mem_ld);
    tick(); chk("lw_mem1", obs_a, e_mem_ld);
    tick(); chk("lw_mem2", obs_a, e_mem_ld);
    tick(); chk("lw_mem3_wait", obs_a, e_mem_ld);
    ready_a = 1'b1; #1;
    chk("lw_mem3_ready", obs_a, e_mem_ld);
    tick(); chk("lw_wb", obs_a, e_wb_ld);
    tick(); chk("lw_refetch", obs_a, e_fetch_rdy);

    // beq then bne, both with zero=1
    inst_a = 32'h00208063; zero_a = 1'b1;
    tick(); chk("beq_decode", obs_a, e_decode);
    tick(); chk("beq_exec", obs_a, e_exec_bt);
    tick(); chk("beq_refetch", obs_a, e_fetch_rdy);
    inst_a = 32'h00209063;
    tick(); chk("bne_decode", obs_a, e_decode);
    tick(); chk("bne_exec", obs_a, e_exec_bn);
    tick(); chk("bne_refetch", obs_a, e_fetch_rdy);
    zero_a = 1'b0;

    // jal with upper/jump support enabled
    inst_a = 32'h0000006F;
    tick(); chk("jal_decode", obs_a, e_decode);
    tick(); chk("jal_exec", obs_a, e_exec_jal);
    tick(); chk("jal_wb", obs_a, e_wb_pc);
    tick(); chk("jal_refetch", obs_a, e_fetch_rdy);

    // sw x2,0(x1) with reset pulsed in the middle of MEM
    inst_a = 32'h0020A023;
    tick(); chk("sw_decode", obs_a, e_decode);
    tick(); chk("sw_exec", obs_a, e_exec_mem);
    ready_a = 1'b0;
    tick(); chk("sw_mem", obs_a, e_mem_st);
    #2; rst_a = 1'b0; #1;
    chk("sw_async_reset", obs_a, e_idle);
    @(negedge clk); rst_a = 1'b1; #1;
    chk("sw_post_idle", obs_a, e_idle);
    tick(); chk("sw_post_fetch", obs_a, e_fetch_wait);

    // jal on a core without upper/jump support traps after DECODE
    @(negedge clk); rst_b = 1'b1; #1;
    chk("nj_idle", obs_b, e_idle);
    tick(); chk("nj_fetch", obs_b, e_fetch_rdy);
    tick(); chk("nj_decode", obs_b, e_decode);
    tick(); chk("nj_trap", obs_b, e_trap);
    ready_b = 1'b0;
    tick(); chk("nj_trap_hold0", obs_b, e_trap);
    ready_b = 1'b1;
    tick(); chk("nj_trap_hold1", obs_b, e_trap);

    // fetch timeout with TIMEOUT_CYCLES=4
    rst_b = 1'b0; ready_b = 1'b0; #1;
    chk("to_reset", obs_b, e_idle);
    @(negedge clk); rst_b = 1'b1;
    tick(); chk("to_fetch0", obs_b, e_fetch_wait);
    for (int i = 1; i <= 4; i++) begin
      tick(); chk($sformatf("to_fetch%0d", i), obs_b, e_fetch_wait);
    end
    tick(); chk("to_trap", obs_b, e_trap);

    // mem_ready arriving in the timeout cycle wins
    rst_b = 1'b0; #1;
    @(negedge clk); rst_b = 1'b1;
    tick(); chk("race_fetch0", obs_b, e_fetch_wait);
    for (int i = 1; i <= 3; i++) tick();
    tick(); chk("race_fetch4_wait", obs_b, e_fetch_wait);
    ready_b = 1'b1; #1;
    chk("race_fetch4_ready", obs_b, e_fetch_rdy);
    tick(); chk("race_decode", obs_b, e_decode);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
